// File: rtl/dogx_ser_pkg.sv
// dogx_ser_pkg: shared frame types, sizes and the frame-word packer (DOGX_SER_PARITY_EN selects parity framing)
package dogx_ser_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} ser_state_t;
  localparam int FRAME_BITS = 16;
  localparam int BITS_PER_LANE = 8;
`ifdef DOGX_SER_PARITY_EN
  localparam int CNT_W = 3;
`else
  localparam int CNT_W = 4;
`endif
  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic alpha, input logic [FRAME_BITS-6:0] data, input logic [3:0] cnt);
`ifdef DOGX_SER_PARITY_EN
    logic [FRAME_BITS-1:0] w;
    w = {alpha, data, cnt[2:0], 1'b0};
    w[0] = ^w[FRAME_BITS-1:1];
    return w;
`else
    return {alpha, data, cnt};
`endif
  endfunction
endpackage

// File: rtl/dogx_output_serializer_if.sv
// dogx_output_serializer_if: sample input and serial output bundle of the output serializer
interface dogx_output_serializer_if #(parameter int DATA_W = 11, parameter int N_LANES = 2);
  logic ser_en;
  logic enable_sampling_3M;
  logic [DATA_W-1:0] converter_output;
  logic alpha;
  logic sync_err_clr;
  logic [N_LANES-1:0] sdata;
  logic frame_sync;
  logic frame_active;
  logic sync_err;
  modport master (output ser_en, enable_sampling_3M, converter_output, alpha, sync_err_clr,
                  input sdata, frame_sync, frame_active, sync_err);
  modport slave (input ser_en, enable_sampling_3M, converter_output, alpha, sync_err_clr,
                 output sdata, frame_sync, frame_active, sync_err);
endinterface

// File: rtl/dogx_ser_lane_shifter.sv
// dogx_ser_lane_shifter: one lane's load/shift register, MSB on the serial output
module dogx_ser_lane_shifter #(parameter int W = 8) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic shift,
  input  logic [W-1:0] din,
  output logic sout
);
  logic [W-1:0] sr_d, sr_q;
  // load wins over clear, clear over shift
  always_comb sr_d = load ? din : clr ? '0 : shift ? {sr_q[W-2:0], 1'b0} : sr_q;
  // lane register
  always_ff @(posedge clk)
    if (rst) sr_q <= '0;
    else sr_q <= sr_d;
  assign sout = sr_q[W-1];
endmodule

// File: rtl/dogx_output_serializer.sv
// dogx_output_serializer: packs strobed samples into 16-bit frames and streams them on serial lanes (DOGX_SER_PARITY_EN adds parity)
module dogx_output_serializer #(
  parameter int DATA_W = 11,
  parameter int N_LANES = 2,
  parameter int BITS_PER_LANE = 8
) (
  input logic CLK_24M,
  input logic reset,
  dogx_output_serializer_if.slave bus
);
  import dogx_ser_pkg::*;
  localparam int BW = $clog2(BITS_PER_LANE);
  if (1 + DATA_W + 4 != N_LANES * BITS_PER_LANE || N_LANES * BITS_PER_LANE != FRAME_BITS) begin : g_bad_cfg
    $error("dogx_output_serializer: frame width does not match lane geometry");
  end
  ser_state_t state_d, state_q;
  logic [BW-1:0] bit_cnt_d, bit_cnt_q;
  logic [CNT_W-1:0] frame_cnt_d, frame_cnt_q;
  logic sync_err_d, sync_err_q, frame_sync_q, frame_active_q;
  logic load, clr, last;
  logic [FRAME_BITS-1:0] word;
  logic [N_LANES-1:0] sdata;
  assign word = pack_frame(bus.alpha, bus.converter_output, 4'(frame_cnt_q));
  assign last = bit_cnt_q == BW'(BITS_PER_LANE - 1);
  // next-state: a strobe mid-frame resyncs and flags, a strobe at the last bit chains gaplessly
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    sync_err_d = sync_err_q & ~bus.sync_err_clr;
    load = 1'b0;
    clr = 1'b0;
    case (state_q)
      IDLE: state_d = bus.ser_en ? ARMED : IDLE;
      ARMED:
        if (!bus.ser_en) state_d = IDLE;
        else load = bus.enable_sampling_3M;
      default:
        if (!last) begin
          load = bus.enable_sampling_3M;
          sync_err_d = sync_err_d | bus.enable_sampling_3M;
          bit_cnt_d = bit_cnt_q + BW'(1);
        end else if (bus.enable_sampling_3M && bus.ser_en) load = 1'b1;
        else begin
          clr = 1'b1;
          state_d = bus.ser_en ? ARMED : IDLE;
        end
    endcase
    if (load) begin
      state_d = SHIFT;
      bit_cnt_d = '0;
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
    if (state_d == IDLE) frame_cnt_d = '0;
  end
  // state, counters and registered status outputs
  always_ff @(posedge CLK_24M)
    if (reset) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      frame_cnt_q <= '0;
      sync_err_q <= 1'b0;
      frame_sync_q <= 1'b0;
      frame_active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      sync_err_q <= sync_err_d;
      frame_sync_q <= load;
      frame_active_q <= state_d == SHIFT;
    end
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    dogx_ser_lane_shifter #(.W(BITS_PER_LANE)) u_lane (
      .clk(CLK_24M),
      .rst(reset),
      .load(load),
      .clr(clr),
      .shift(state_q == SHIFT),
      .din(word[FRAME_BITS-1-i*BITS_PER_LANE -: BITS_PER_LANE]),
      .sout(sdata[i])
    );
  end
  assign bus.sdata = sdata;
  assign bus.frame_sync = frame_sync_q;
  assign bus.frame_active = frame_active_q;
  assign bus.sync_err = sync_err_q;
endmodule
